ctr_seq: RTL and testbench

Command sequencer that drives the existing up/down/load counter `ctr` through its `mode_in`/`data_in` interface. It closes the loop on the counter's `data_out`. On a start command it loads a low bound, then sweeps the counter up to a high bound and back down, for a programmed number of repetitions. It then parks the counter in hold and pulses done. It sits between a host/control block and a `ctr` instance, and also serves as a synthesizable stimulus source for `ctr` benches.

---
 rtl/ctr_pkg.sv | 31 +++
 rtl/ctr.sv | 29 ++
 rtl/ctr_seq.sv | 119 +++++++++++
 tb/tb_ctr_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ctr_pkg.sv
// Shared types for the up/down/load counter and its command sequencer.
// Mode encoding is common to both blocks so they can be wired back-to-back.
package ctr_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    function automatic mode_t mode_of(input seq_state_t st);
        mode_t m;
        case (st)
            ST_LOAD: m = MODE_LOAD;
            ST_UP:   m = MODE_UP;
            ST_DOWN: m = MODE_DOWN;
            default: m = MODE_HOLD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ctr.sv
// Up/down/load counter driven by a 2-bit mode; acts on mode at every rising edge.
module ctr
    import ctr_pkg::*;
#(
    parameter int BITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  mode_t           mode_in,
    input  logic [BITS-1:0] data_in,
    output logic [BITS-1:0] data_out
);

    // Counter register: hold, increment, decrement or load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            case (mode_in)
                MODE_HOLD: data_out <= data_out;
                MODE_UP:   data_out <= data_out + BITS'(1);
                MODE_DOWN: data_out <= data_out - BITS'(1);
                MODE_LOAD: data_out <= data_in;
                default:   data_out <= data_out;
            endcase
        end
    end

endmodule

// File: rtl/ctr_seq.sv
// Sequencer that loads a counter with a low bound and sweeps it up to a high bound
// and back down for a programmed number of repetitions, closing the loop on ctr_in.
module ctr_seq
    import ctr_pkg::*;
#(
    parameter int BITS     = 3,
    parameter int REP_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_in,
    input  logic                abort_in,
    input  logic [BITS-1:0]     lo_in,
    input  logic [BITS-1:0]     hi_in,
    input  logic [REP_BITS-1:0] reps_in,
    input  logic [BITS-1:0]     ctr_in,
    output mode_t               mode_out,
    output logic [BITS-1:0]     data_out,
    output logic                busy_out,
    output logic                done_out,
    output logic                err_out
);

    seq_state_t          state_r;
    seq_state_t          w_next_state;
    logic [BITS-1:0]     lo_r;
    logic [BITS-1:0]     hi_r;
    logic [REP_BITS-1:0] rep_r;
    logic                err_r;
    logic                w_latch;
    logic                w_rep_dec;
    logic                w_err;
    logic [BITS-1:0]     w_hi_m1;
    logic [BITS-1:0]     w_lo_p1;

    // lo_r < hi_r is guaranteed for any run, so neither neighbour wraps.
    assign w_hi_m1 = hi_r - BITS'(1);
    assign w_lo_p1 = lo_r + BITS'(1);

    // Next-state decode; abort overrides every other request.
    always_comb begin
        w_next_state = state_r;
        w_latch      = 1'b0;
        w_rep_dec    = 1'b0;
        w_err        = 1'b0;
        if (abort_in) begin
            w_next_state = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_in) begin
                        if (lo_in >= hi_in) begin
                            w_err = 1'b1;
                        end else if (reps_in == '0) begin
                            w_next_state = ST_DONE;
                        end else begin
                            w_next_state = ST_LOAD;
                            w_latch      = 1'b1;
                        end
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_LOAD: w_next_state = ST_UP;
                ST_UP: begin
                    if (ctr_in == w_hi_m1) begin
                        w_next_state = ST_DOWN;
                    end else begin
                        w_next_state = ST_UP;
                    end
                end
                ST_DOWN: begin
                    if (ctr_in == w_lo_p1) begin
                        w_rep_dec = 1'b1;
                        if (rep_r == REP_BITS'(1)) begin
                            w_next_state = ST_DONE;
                        end else begin
                            w_next_state = ST_UP;
                        end
                    end else begin
                        w_next_state = ST_DOWN;
                    end
                end
                ST_DONE: w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // State, latched run parameters and the reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            lo_r    <= '0;
            hi_r    <= '0;
            rep_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= w_next_state;
            err_r   <= w_err;
            if (w_latch) begin
                lo_r  <= lo_in;
                hi_r  <= hi_in;
                rep_r <= reps_in;
            end else if (w_rep_dec) begin
                rep_r <= rep_r - REP_BITS'(1);
            end else begin
                rep_r <= rep_r;
            end
        end
    end

    assign mode_out = mode_of(state_r);
    assign data_out = lo_r;
    assign busy_out = (state_r == ST_LOAD) || (state_r == ST_UP) || (state_r == ST_DOWN);
    assign done_out = (state_r == ST_DONE);
    assign err_out  = err_r;

endmodule

// File: tb/tb_ctr_seq.sv
// Bench for ctr_seq driving a ctr instance; expected counter trajectories are
// generated from the sweep rules and compared every cycle.
module tb_ctr_seq;
    import ctr_pkg::*;

    localparam int BITS     = 3;
    localparam int REP_BITS = 4;

    logic                clk;
    logic                rst_n;
    logic                start_in;
    logic                abort_in;
    logic [BITS-1:0]     lo_in;
    logic [BITS-1:0]     hi_in;
    logic [REP_BITS-1:0] reps_in;
    logic [BITS-1:0]     w_cnt;
    mode_t               w_mode;
    logic [BITS-1:0]     w_data;
    logic                w_busy;
    logic                w_done;
    logic                w_err;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    int model_lo  = 0;

    ctr_seq #(.BITS(BITS), .REP_BITS(REP_BITS)) u_seq (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .abort_in(abort_in),
        .lo_in(lo_in), .hi_in(hi_in), .reps_in(reps_in), .ctr_in(w_cnt),
        .mode_out(w_mode), .data_out(w_data), .busy_out(w_busy),
        .done_out(w_done), .err_out(w_err)
    );

    ctr #(.BITS(BITS)) u_ctr (
        .clk(clk), .rst_n(rst_n), .mode_in(w_mode), .data_in(w_data), .data_out(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input int mode,
                           input int busy, input int done, input int err);
        chk({tag, ".cnt"},  32'(w_cnt),  cnt);
        chk({tag, ".mode"}, 32'(w_mode), mode);
        chk({tag, ".busy"}, 32'(w_busy), busy);
        chk({tag, ".done"}, 32'(w_done), done);
        chk({tag, ".err"},  32'(w_err),  err);
        chk({tag, ".data"}, 32'(w_data), model_lo);
    endtask

    task automatic drive_start(input int lo, input int hi, input int reps, input bit abort);
        start_in = 1'b1;
        abort_in = abort;
        lo_in    = BITS'(lo);
        hi_in    = BITS'(hi);
        reps_in  = REP_BITS'(reps);
    endtask

    // Full accepted run; called just after a negedge with the sequencer idle.
    task automatic run_seq(input int lo, input int hi, input int reps, input bit poke);
        int exp_q[$];
        int span;
        span = hi - lo;
        for (int r = 0; r < reps; r++) begin
            for (int v = lo; v < hi; v++) exp_q.push_back(v);
            for (int v = hi; v > lo; v--) exp_q.push_back(v);
        end
        drive_start(lo, hi, reps, 1'b0);
        @(negedge clk);
        start_in = 1'b0;
        model_lo = lo;
        chk_all("load", model_cnt, 3, 1, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            start_in = 1'b0;
            chk_all("sweep", exp_q[i], ((i % (2 * span)) < span) ? 1 : 2, 1, 0, 0);
            if (poke && i == 1) drive_start(0, 7, 9, 1'b0);
        end
        @(negedge clk);
        chk_all("done", lo, 0, 0, 1, 0);
        @(negedge clk);
        chk_all("idle", lo, 0, 0, 0, 0);
        model_cnt = lo;
    endtask

    task automatic run_reject(input int lo, input int hi, input int reps);
        drive_start(lo, hi, reps, 1'b0);
        @(negedge clk);
        start_in = 1'b0;
        chk_all("reject", model_cnt, 0, 0, 0, 1);
        @(negedge clk);
        chk_all("reject_after", model_cnt, 0, 0, 0, 0);
    endtask

    task automatic run_zero(input int lo, input int hi);
        drive_start(lo, hi, 0, 1'b0);
        @(negedge clk);
        start_in = 1'b0;
        chk_all("zero_done", model_cnt, 0, 0, 1, 0);
        @(negedge clk);
        chk_all("zero_after", model_cnt, 0, 0, 0, 0);
    endtask

    task automatic dispatch(input int lo, input int hi, input int reps);
        if (lo >= hi) run_reject(lo, hi, reps);
        else if (reps == 0) run_zero(lo, hi);
        else run_seq(lo, hi, reps, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start_in = 1'b0;
        abort_in = 1'b0;
        lo_in    = '0;
        hi_in    = '0;
        reps_in  = '0;
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("post_reset", 0, 0, 0, 0, 0);

        run_seq(1, 4, 2, 1'b0);
        run_seq(5, 6, 3, 1'b0);
        run_reject(4, 4, 2);
        run_zero(0, 7);

        // Abort while the counter reads 3 in UP: counter stops at 4.
        drive_start(0, 7, 1, 1'b0);
        @(negedge clk);
        start_in = 1'b0;
        model_lo = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_all("pre_abort", i, 1, 1, 0, 0);
        end
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        chk_all("abort", 4, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("abort_hold", 4, 0, 0, 0, 0);
        model_cnt = 4;
        run_seq(2, 5, 1, 1'b0);

        run_seq(1, 6, 1, 1'b1);

        drive_start(1, 3, 1, 1'b1);
        @(negedge clk);
        start_in = 1'b0;
        abort_in = 1'b0;
        chk_all("collide", model_cnt, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("collide_after", model_cnt, 0, 0, 0, 0);

        for (int k = 0; k < 25; k++) begin
            dispatch(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)));
        end

        // Asynchronous reset during DOWN.
        drive_start(1, 4, 2, 1'b0);
        @(negedge clk);
        start_in = 1'b0;
        model_lo = 1;
        repeat (4) @(negedge clk);
        chk_all("pre_reset", 4, 2, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_lo = 0;
        chk_all("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
        @(negedge clk);
        chk_all("reset_idle", 0, 0, 0, 0, 0);
        run_seq(0, 2, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
